fifo_pop_arbiter: RTL and testbench



---
 rtl/fifo_pop_arbiter_pkg.sv | 15 +
 rtl/fifo_pop_arbiter_rr_grant4.sv | 26 ++
 rtl/fifo_pop_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_pop_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pop_arbiter_pkg.sv
// Shared constants and helpers for the FIFO pop arbiter.
package fifo_pop_arbiter_pkg;

   localparam int NUM_PORTS = 4;
   localparam int DEST_W    = 2;

   // Destination index lives in the top DEST_W bits of a width-bit word.
   function automatic logic [DEST_W-1:0] get_dest(input logic [31:0] word,
                                                  input int unsigned width);
      logic [31:0] sh;
      sh = word >> (width - DEST_W);
      return sh[DEST_W-1:0];
   endfunction

endpackage

// File: rtl/fifo_pop_arbiter_rr_grant4.sv
// Combinational round-robin priority encoder over four requesters.
module rr_grant4
   import fifo_pop_arbiter_pkg::*;
(
   input  logic [NUM_PORTS-1:0] eligible,
   input  logic [1:0]           ptr,
   output logic [1:0]           grant,
   output logic                 grant_vld
);

   // Scan from farthest to nearest so the first eligible index at/after ptr wins.
   always_comb begin
      logic [1:0] idx;
      grant     = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int k = NUM_PORTS-1; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (eligible[idx]) begin
            grant     = idx;
            grant_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// Round-robin pop arbiter: pops one input FIFO per cycle and pushes the
// word to the output FIFO named by its destination bits two cycles later.
// Optional feature: define ARB_PUSH_COUNT_EN to add per-output push counters.
module fifo_pop_arbiter
   import fifo_pop_arbiter_pkg::*;
#(
   parameter int data_width = 10
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_PORTS-1:0]  fifo_empty,
   input  logic [data_width-1:0] fifo_data_0,
   input  logic [data_width-1:0] fifo_data_1,
   input  logic [data_width-1:0] fifo_data_2,
   input  logic [data_width-1:0] fifo_data_3,
   input  logic [NUM_PORTS-1:0]  almost_full,
   output logic [NUM_PORTS-1:0]  pop,
   output logic [NUM_PORTS-1:0]  push,
   output logic [data_width-1:0] data_out,
   output logic                  active
`ifdef ARB_PUSH_COUNT_EN
  ,output logic [31:0]           push_count
`endif
);

   localparam int STAGES = 1;

   logic [NUM_PORTS-1:0][data_width-1:0] fifo_data;
   logic [STAGES:0]       vld_pipe;   // [0]: pop issued this cycle, [1]: data being sampled
   logic [1:0]            ptr;
   logic [1:0]            src1;
   logic [1:0]            src2;
   logic [1:0]            grant;
   logic                  grant_vld;
   logic [NUM_PORTS-1:0]  eligible;
   logic                  stall;
   logic [data_width-1:0] word2;

   assign fifo_data[0] = fifo_data_0;
   assign fifo_data[1] = fifo_data_1;
   assign fifo_data[2] = fifo_data_2;
   assign fifo_data[3] = fifo_data_3;

   // A FIFO popped this cycle still shows its stale empty flag; skip it.
   assign eligible = ~fifo_empty & ~pop;
   assign stall    = |almost_full;
   assign word2    = fifo_data[src2];
   assign active   = |vld_pipe;

   rr_grant4 u_grant (
      .eligible  (eligible),
      .ptr       (ptr),
      .grant     (grant),
      .grant_vld (grant_vld)
   );

   // Pop issue, source tracking through the pipe, and push generation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pop      <= '0;
         push     <= '0;
         data_out <= '0;
         ptr      <= '0;
         src1     <= '0;
         src2     <= '0;
         vld_pipe <= '0;
      end else begin
         if (!stall && grant_vld) begin
            pop         <= 4'b0001 << grant;
            src1        <= grant;
            vld_pipe[0] <= 1'b1;
            ptr         <= grant + 2'd1;
         end else begin
            pop         <= '0;
            vld_pipe[0] <= 1'b0;
         end
         vld_pipe[1] <= vld_pipe[0];
         src2        <= src1;
         if (vld_pipe[1]) begin
            push     <= 4'b0001 << get_dest(32'(word2), data_width);
            data_out <= word2;
         end else begin
            push     <= '0;
         end
      end
   end

`ifdef ARB_PUSH_COUNT_EN
   logic [NUM_PORTS-1:0][7:0] cnt;

   assign push_count = cnt;

   // Per-output wrapping push counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else begin
         for (int j = 0; j < NUM_PORTS; j++)
            if (push[j]) cnt[j] <= cnt[j] + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Randomized self-checking bench for fifo_pop_arbiter against a queue-based model.
module tb_fifo_pop_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] fifo_empty = 4'hF;
   logic [3:0][9:0] fdata = '0;
   logic [3:0] almost_full = 4'h0;
   logic [3:0] pop, push;
   logic [9:0] data_out;
   logic       active;
`ifdef ARB_PUSH_COUNT_EN
   logic [31:0] push_count;
`endif

   int n_chk = 0;
   int n_fail = 0;

   fifo_pop_arbiter #(.data_width(10)) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
      .fifo_data_0(fdata[0]), .fifo_data_1(fdata[1]),
      .fifo_data_2(fdata[2]), .fifo_data_3(fdata[3]),
      .almost_full(almost_full), .pop(pop), .push(push),
      .data_out(data_out), .active(active)
`ifdef ARB_PUSH_COUNT_EN
     ,.push_count(push_count)
`endif
   );

   always #5 clk = ~clk;

   // Input FIFO emulation: registered data and registered empty flag.
   logic [9:0] q[4][$];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (pop[i] && q[i].size() != 0) fdata[i] <= q[i].pop_front();
         fifo_empty[i] <= (q[i].size() == 0);
      end
   end

   // Reference model state: words in flight by age (0 = popped this cycle).
   int         m_ptr;
   logic [3:0] e_pop;
   logic       pv[3];
   logic [9:0] pw[3];
   logic [9:0] e_dout;
   logic [7:0] m_cnt[4];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_ptr = 0; e_pop = 0; e_dout = 0;
      for (int k = 0; k < 3; k++) begin pv[k] = 0; pw[k] = 0; end
      for (int j = 0; j < 4; j++) m_cnt[j] = 0;
   endtask

   // Advance the model to the next cycle from the inputs the next edge will see.
   task automatic model_next();
      int g;
      if (pv[2]) m_cnt[pw[2][9:8]] = m_cnt[pw[2][9:8]] + 8'd1;
      pv[2] = pv[1]; pw[2] = pw[1];
      pv[1] = pv[0]; pw[1] = pw[0];
      if (pv[2]) e_dout = pw[2];
      g = -1;
      if (almost_full == 0)
         for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (g < 0 && !fifo_empty[i] && !e_pop[i]) g = i;
         end
      if (g >= 0) begin
         e_pop = 4'b0001 << g;
         pv[0] = 1'b1;
         pw[0] = (q[g].size() != 0) ? q[g][0] : 10'h3FF;
         m_ptr = (g + 1) % 4;
      end else begin
         e_pop = 0;
         pv[0] = 1'b0;
      end
   endtask

   // One clock: update model, move to the next negedge, compare everything.
   task automatic tick();
      logic [3:0] e_push;
      if (!reset) model_clear(); else model_next();
      @(negedge clk);
      e_push = pv[2] ? (4'b0001 << pw[2][9:8]) : 4'b0000;
      chk("pop", 32'(pop), 32'(e_pop));
      chk("push", 32'(push), 32'(e_push));
      chk("data_out", 32'(data_out), 32'(e_dout));
      chk("active", 32'(active), 32'(pv[0] | pv[1]));
`ifdef ARB_PUSH_COUNT_EN
      chk("push_count", push_count, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
`endif
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      model_clear();
      @(negedge clk);
      // Reset held with all inputs non-empty: outputs stay quiet.
      q[0].push_back(10'h010); q[1].push_back(10'h169);
      q[2].push_back(10'h239); q[3].push_back(10'h04F);
      ticks(4);
      // Round-robin across all four sources.
      reset = 1'b1;
      ticks(8);
      // Single source alternates pops.
      q[2].push_back(10'h1A5); q[2].push_back(10'h0FF);
      ticks(8);
      // Back-pressure mid-stream.
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) q[i].push_back(10'($urandom));
      ticks(3);
      almost_full = 4'b1000;
      ticks(4);
      almost_full = 4'b0000;
      ticks(12);
      // Reset one cycle after a pop.
      q[1].push_back(10'h3C3); q[3].push_back(10'h2AA);
      ticks(2);
      reset = 1'b0;
      ticks(3);
      reset = 1'b1;
      ticks(8);
      // Random traffic with back-pressure and occasional resets.
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(2) == 0 && q[i].size() < 8) q[i].push_back(10'($urandom));
         almost_full = ($urandom_range(4) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
         if (!reset) reset = 1'b1;
         else if ($urandom_range(199) == 0) reset = 1'b0;
         tick();
      end
      almost_full = 4'h0;
      reset = 1'b1;
      ticks(10);
      // 260 words to destination 3 from a clean reset.
      reset = 1'b0;
      ticks(2);
      for (int i = 0; i < 4; i++) q[i].delete();
      ticks(2);
      reset = 1'b1;
      for (int w = 0; w < 260; w++) q[w % 4].push_back({2'b11, 8'($urandom)});
      ticks(340);
`ifdef ARB_PUSH_COUNT_EN
      chk("push_count_260", push_count, 32'h0400_0000);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
